// File: rtl/ps2_pkg.sv
// Shared PS/2 host definitions: init FSM state encoding, command/response bytes
// and timeout counter sizing.
package ps2_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SEND_RST,
        ST_WAIT_TX_RST,
        ST_WAIT_ACK_RST,
        ST_WAIT_BAT,
        ST_WAIT_ID,
        ST_SEND_EN,
        ST_WAIT_TX_EN,
        ST_WAIT_ACK_EN,
        ST_DONE,
        ST_ERROR
    } ps2_state_t;

    localparam logic [7:0] PS2_CMD_RESET     = 8'hFF;
    localparam logic [7:0] PS2_CMD_EN_REPORT = 8'hF4;
    localparam logic [7:0] PS2_RSP_ACK       = 8'hFA;
    localparam logic [7:0] PS2_RSP_BAT_OK    = 8'hAA;
    localparam logic [7:0] PS2_ID_MOUSE      = 8'h00;

    // BAT can take up to 500 ms, so its wait uses a 25x longer limit.
    localparam int unsigned PS2_BAT_MULT = 25;
    localparam int unsigned PS2_TO_W     = 25;

endpackage

// File: rtl/ps2_timeout_cnt.sv
// Response timeout counter: cleared on state entry, counts while enabled,
// flags expiry when the selected limit minus one is reached.
module ps2_timeout_cnt
    import ps2_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
    input  logic clk_sys,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    input  logic i_long,
    output logic o_expire
);

    localparam logic [PS2_TO_W-1:0] LIM_SHORT = PS2_TO_W'(TIMEOUT_CYC - 1);
    localparam logic [PS2_TO_W-1:0] LIM_LONG  = PS2_TO_W'(PS2_BAT_MULT * TIMEOUT_CYC - 1);

    logic [PS2_TO_W-1:0] r_cnt;
    logic [PS2_TO_W-1:0] w_limit;

    assign w_limit  = i_long ? LIM_LONG : LIM_SHORT;
    assign o_expire = i_en && (r_cnt == w_limit);

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && !o_expire) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/ps2_host_init.sv
// PS/2 mouse host initialisation: reset, BAT/ID check, enable reporting, with
// timeout-driven retries; forwards received bytes once initialised.
module ps2_host_init
    import ps2_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 1_000_000,
    parameter int unsigned MAX_RETRY   = 3
) (
    input  logic       clk_sys,
    input  logic       rst_n,
    input  logic       start,
    output logic       tx_wr_en,
    output logic [7:0] tx_wr_data,
    input  logic       tx_wr_done,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic       busy,
    output logic       init_done,
    output logic       init_err,
    output logic [1:0] retry_cnt,
    output logic       pkt_valid,
    output logic [7:0] pkt_data
);

    ps2_state_t r_state, w_next;

    logic       r_tx_wr_en;
    logic [7:0] r_tx_wr_data;
    logic       r_busy, r_init_done, r_init_err;
    logic [1:0] r_retry_cnt;
    logic       r_pkt_valid;
    logic [7:0] r_pkt_data;

    logic w_fail, w_start_ok, w_to_en, w_to_long, w_to_clr, w_expire;

    assign w_start_ok = start && (r_state inside {ST_IDLE, ST_DONE, ST_ERROR});
    assign w_to_en    = r_state inside {ST_WAIT_TX_RST, ST_WAIT_ACK_RST, ST_WAIT_BAT,
                                        ST_WAIT_ID, ST_WAIT_TX_EN, ST_WAIT_ACK_EN};
    assign w_to_long  = (r_state == ST_WAIT_BAT);
    assign w_to_clr   = (w_next != r_state);

    ps2_timeout_cnt #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
        .clk_sys  (clk_sys),
        .rst_n    (rst_n),
        .i_clr    (w_to_clr),
        .i_en     (w_to_en),
        .i_long   (w_to_long),
        .o_expire (w_expire)
    );

    // A received byte is checked before the timeout so a same-cycle match advances.
    always_comb begin
        w_next = r_state;
        w_fail = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE, ST_ERROR: if (w_start_ok) w_next = ST_SEND_RST;
            ST_SEND_RST:    w_next = ST_WAIT_TX_RST;
            ST_WAIT_TX_RST: begin
                if (tx_wr_done)    w_next = ST_WAIT_ACK_RST;
                else if (w_expire) w_fail = 1'b1;
            end
            ST_WAIT_ACK_RST: begin
                if (rx_valid) begin
                    if (rx_data == PS2_RSP_ACK) w_next = ST_WAIT_BAT;
                    else                        w_fail = 1'b1;
                end else if (w_expire) w_fail = 1'b1;
            end
            ST_WAIT_BAT: begin
                if (rx_valid) begin
                    if (rx_data == PS2_RSP_BAT_OK) w_next = ST_WAIT_ID;
                    else                           w_fail = 1'b1;
                end else if (w_expire) w_fail = 1'b1;
            end
            ST_WAIT_ID: begin
                if (rx_valid) begin
                    if (rx_data == PS2_ID_MOUSE) w_next = ST_SEND_EN;
                    else                         w_fail = 1'b1;
                end else if (w_expire) w_fail = 1'b1;
            end
            ST_SEND_EN:     w_next = ST_WAIT_TX_EN;
            ST_WAIT_TX_EN: begin
                if (tx_wr_done)    w_next = ST_WAIT_ACK_EN;
                else if (w_expire) w_fail = 1'b1;
            end
            ST_WAIT_ACK_EN: begin
                if (rx_valid) begin
                    if (rx_data == PS2_RSP_ACK) w_next = ST_DONE;
                    else                        w_fail = 1'b1;
                end else if (w_expire) w_fail = 1'b1;
            end
            default:        w_next = ST_IDLE;
        endcase
        if (w_fail) begin
            w_next = (32'(r_retry_cnt) < MAX_RETRY) ? ST_SEND_RST : ST_ERROR;
        end
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_tx_wr_en   <= 1'b0;
            r_tx_wr_data <= '0;
            r_busy       <= 1'b0;
            r_init_done  <= 1'b0;
            r_init_err   <= 1'b0;
            r_retry_cnt  <= '0;
            r_pkt_valid  <= 1'b0;
            r_pkt_data   <= '0;
        end else begin
            r_state     <= w_next;
            r_tx_wr_en  <= (w_next == ST_SEND_RST) || (w_next == ST_SEND_EN);
            if (w_next == ST_SEND_RST)     r_tx_wr_data <= PS2_CMD_RESET;
            else if (w_next == ST_SEND_EN) r_tx_wr_data <= PS2_CMD_EN_REPORT;
            r_busy      <= !(w_next inside {ST_IDLE, ST_DONE, ST_ERROR});
            r_init_done <= (w_next == ST_DONE);
            r_init_err  <= (w_next == ST_ERROR);
            if (w_start_ok)                            r_retry_cnt <= '0;
            else if (w_fail && w_next == ST_SEND_RST) r_retry_cnt <= r_retry_cnt + 1'b1;
            r_pkt_valid <= (r_state == ST_DONE) && (w_next == ST_DONE) && rx_valid;
            if ((r_state == ST_DONE) && rx_valid)     r_pkt_data <= rx_data;
        end
    end

    assign tx_wr_en   = r_tx_wr_en;
    assign tx_wr_data = r_tx_wr_data;
    assign busy       = r_busy;
    assign init_done  = r_init_done;
    assign init_err   = r_init_err;
    assign retry_cnt  = r_retry_cnt;
    assign pkt_valid  = r_pkt_valid;
    assign pkt_data   = r_pkt_data;

endmodule

// File: tb/tb_ps2_host_init.sv
// Directed self-checking bench for ps2_host_init with a shortened timeout.
module tb_ps2_host_init;

    logic       clk_sys = 1'b0;
    logic       rst_n;
    logic       start;
    logic       tx_wr_en;
    logic [7:0] tx_wr_data;
    logic       tx_wr_done;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       busy, init_done, init_err;
    logic [1:0] retry_cnt;
    logic       pkt_valid;
    logic [7:0] pkt_data;

    int n_checks = 0;
    int n_fail   = 0;
    int strobe_cnt = 0;
    logic [7:0] strobe_log[$];

    ps2_host_init #(.TIMEOUT_CYC(1000), .MAX_RETRY(3)) dut (
        .clk_sys    (clk_sys),
        .rst_n      (rst_n),
        .start      (start),
        .tx_wr_en   (tx_wr_en),
        .tx_wr_data (tx_wr_data),
        .tx_wr_done (tx_wr_done),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .busy       (busy),
        .init_done  (init_done),
        .init_err   (init_err),
        .retry_cnt  (retry_cnt),
        .pkt_valid  (pkt_valid),
        .pkt_data   (pkt_data)
    );

    always #5 clk_sys = ~clk_sys;

    always @(negedge clk_sys) begin
        if (rst_n === 1'b1 && tx_wr_en === 1'b1) begin
            strobe_cnt++;
            strobe_log.push_back(tx_wr_data);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic pulse_start();
        @(posedge clk_sys); #1 start = 1'b1;
        @(posedge clk_sys); #1 start = 1'b0;
    endtask

    task automatic send_rx(input logic [7:0] b);
        @(posedge clk_sys); #1 rx_valid = 1'b1; rx_data = b;
        @(posedge clk_sys); #1 rx_valid = 1'b0; rx_data = 8'h00;
    endtask

    task automatic send_done(input int dly, output logic [7:0] held);
        repeat (dly - 1) @(posedge clk_sys);
        @(negedge clk_sys); held = tx_wr_data;
        @(posedge clk_sys); #1 tx_wr_done = 1'b1;
        @(posedge clk_sys); #1 tx_wr_done = 1'b0;
    endtask

    task automatic wait_strobe(input int max_cyc, output logic ok, output logic [7:0] d);
        int c0;
        c0 = strobe_cnt;
        ok = 1'b0;
        d  = 8'h00;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk_sys); #1;
            if (strobe_cnt != c0) begin
                ok = 1'b1;
                d  = strobe_log[strobe_log.size() - 1];
                break;
            end
        end
    endtask

    // From the first 0xFF strobe onward: all normal replies through to DONE.
    task automatic finish_from_tx_rst(output logic ok);
        logic [7:0] h, d;
        logic       s;
        send_done(100, h);
        send_rx(8'hFA);
        send_rx(8'hAA);
        send_rx(8'h00);
        wait_strobe(50, s, d);
        send_done(100, h);
        send_rx(8'hFA);
        @(negedge clk_sys);
        ok = s && (d == 8'hF4) && (init_done === 1'b1);
    endtask

    task automatic run_init(output logic ok);
        logic [7:0] d;
        logic       s, f;
        wait_strobe(50, s, d);
        finish_from_tx_rst(f);
        ok = s && (d == 8'hFF) && f;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [23:0] v;
        @(negedge clk_sys);
        v = {tx_wr_en, busy, init_done, init_err, pkt_valid, retry_cnt, tx_wr_data, pkt_data, 1'b0};
        n_checks++;
        if (v !== 24'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h, expected %h", v, 24'h0);
        end
    endtask

    task automatic test_normal();
        int s0;
        logic ok;
        logic [7:0] d, h;
        s0 = strobe_cnt;
        pulse_start();
        wait_strobe(20, ok, d);
        n_checks++;
        if (!(ok && d === 8'hFF)) begin n_fail++; $display("FAIL normal_rst_strobe: got ok=%0b data=%h, expected ok=1 data=ff", ok, d); end
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL normal_busy: got %b, expected 1", busy); end
        send_done(100, h);
        n_checks++;
        if (h !== 8'hFF) begin n_fail++; $display("FAIL normal_rst_hold: got %h, expected ff", h); end
        send_rx(8'hFA);
        send_rx(8'hAA);
        send_rx(8'h00);
        wait_strobe(50, ok, d);
        n_checks++;
        if (!(ok && d === 8'hF4)) begin n_fail++; $display("FAIL normal_en_strobe: got ok=%0b data=%h, expected ok=1 data=f4", ok, d); end
        send_done(100, h);
        n_checks++;
        if (h !== 8'hF4) begin n_fail++; $display("FAIL normal_en_hold: got %h, expected f4", h); end
        send_rx(8'hFA);
        @(negedge clk_sys);
        n_checks++;
        if ({init_done, busy, init_err} !== 3'b100) begin
            n_fail++; $display("FAIL normal_done_flags: got done/busy/err=%b, expected 100", {init_done, busy, init_err});
        end
        n_checks++;
        if (retry_cnt !== 2'd0) begin n_fail++; $display("FAIL normal_retry: got %0d, expected 0", retry_cnt); end
        n_checks++;
        if (strobe_cnt - s0 != 2) begin n_fail++; $display("FAIL normal_strobe_count: got %0d, expected 2", strobe_cnt - s0); end
    endtask

    task automatic test_nak_retry();
        logic ok;
        logic [7:0] d, h;
        pulse_start();
        wait_strobe(20, ok, d);
        send_done(100, h);
        send_rx(8'hFC);
        wait_strobe(10, ok, d);
        n_checks++;
        if (!(ok && d === 8'hFF)) begin n_fail++; $display("FAIL nak_second_strobe: got ok=%0b data=%h, expected ok=1 data=ff", ok, d); end
        n_checks++;
        if (retry_cnt !== 2'd1) begin n_fail++; $display("FAIL nak_retry_cnt: got %0d, expected 1", retry_cnt); end
        finish_from_tx_rst(ok);
        n_checks++;
        if (!(ok && retry_cnt === 2'd1)) begin
            n_fail++; $display("FAIL nak_done: got ok=%0b retry=%0d, expected ok=1 retry=1", ok, retry_cnt);
        end
    endtask

    task automatic test_timeout_error();
        int s0;
        logic ok, seen;
        logic [7:0] d, h;
        s0 = strobe_cnt;
        pulse_start();
        for (int k = 0; k < 4; k++) begin
            wait_strobe(3000, ok, d);
            n_checks++;
            if (!(ok && d === 8'hFF)) begin
                n_fail++; $display("FAIL timeout_strobe_%0d: got ok=%0b data=%h, expected ok=1 data=ff", k, ok, d);
            end
            send_done(100, h);
        end
        seen = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk_sys);
            if (init_err === 1'b1) begin seen = 1'b1; break; end
        end
        n_checks++;
        if (!seen) begin n_fail++; $display("FAIL timeout_err: got init_err=%b within bound, expected 1", init_err); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL timeout_busy: got %b, expected 0", busy); end
        n_checks++;
        if (retry_cnt !== 2'd3) begin n_fail++; $display("FAIL timeout_retry: got %0d, expected 3", retry_cnt); end
        n_checks++;
        if (strobe_cnt - s0 != 4) begin n_fail++; $display("FAIL timeout_strobe_count: got %0d, expected 4", strobe_cnt - s0); end
    endtask

    task automatic test_pkt_passthrough();
        logic ok;
        pulse_start();
        run_init(ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL pkt_init: got ok=%0b, expected 1", ok); end
        n_checks++;
        if (pkt_valid !== 1'b0) begin n_fail++; $display("FAIL pkt_idle: got %b, expected 0", pkt_valid); end
        send_rx(8'h08);
        @(negedge clk_sys);
        n_checks++;
        if ({pkt_valid, pkt_data} !== {1'b1, 8'h08}) begin
            n_fail++; $display("FAIL pkt_forward: got valid=%b data=%h, expected valid=1 data=08", pkt_valid, pkt_data);
        end
        @(negedge clk_sys);
        n_checks++;
        if (pkt_valid !== 1'b0) begin n_fail++; $display("FAIL pkt_one_cycle: got %b, expected 0", pkt_valid); end
    endtask

    task automatic test_wait_id_bad();
        int s0;
        logic ok;
        logic [7:0] d, h;
        pulse_start();
        wait_strobe(20, ok, d);
        send_done(100, h);
        send_rx(8'hFA);
        send_rx(8'hAA);
        s0 = strobe_cnt;
        send_rx(8'h08);
        @(negedge clk_sys); #1;
        n_checks++;
        if (pkt_valid !== 1'b0) begin n_fail++; $display("FAIL id_no_pkt: got %b, expected 0", pkt_valid); end
        n_checks++;
        if (!(strobe_cnt == s0 + 1 && strobe_log[strobe_log.size() - 1] === 8'hFF)) begin
            n_fail++; $display("FAIL id_retry_strobe: got count delta=%0d, expected 1 with data ff", strobe_cnt - s0);
        end
        n_checks++;
        if (retry_cnt !== 2'd1) begin n_fail++; $display("FAIL id_retry_cnt: got %0d, expected 1", retry_cnt); end
        finish_from_tx_rst(ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL id_done: got ok=%0b, expected 1", ok); end
    endtask

    task automatic test_reset_mid();
        int s0;
        logic ok;
        logic [7:0] d, h;
        logic [23:0] v;
        pulse_start();
        wait_strobe(20, ok, d);
        send_done(100, h);
        send_rx(8'hFA);
        send_rx(8'hAA);
        send_rx(8'h00);
        wait_strobe(50, ok, d);
        send_done(100, h);
        repeat (10) @(posedge clk_sys);
        #2 rst_n = 1'b0;
        #1;
        v = {tx_wr_en, busy, init_done, init_err, pkt_valid, retry_cnt, tx_wr_data, pkt_data, 1'b0};
        n_checks++;
        if (v !== 24'h0) begin n_fail++; $display("FAIL rstmid_outputs: got %h, expected %h", v, 24'h0); end
        repeat (3) @(negedge clk_sys);
        rst_n = 1'b1;
        s0 = strobe_cnt;
        repeat (20) @(negedge clk_sys);
        n_checks++;
        if (strobe_cnt != s0) begin n_fail++; $display("FAIL rstmid_no_strobe: got %0d strobes, expected 0", strobe_cnt - s0); end
        pulse_start();
        wait_strobe(20, ok, d);
        n_checks++;
        if (!(ok && d === 8'hFF)) begin n_fail++; $display("FAIL rstmid_restart: got ok=%0b data=%h, expected ok=1 data=ff", ok, d); end
        finish_from_tx_rst(ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL rstmid_done: got ok=%0b, expected 1", ok); end
    endtask

    task automatic test_start_ignored();
        int s0;
        logic ok;
        logic [7:0] d, h;
        pulse_start();
        wait_strobe(20, ok, d);
        send_done(100, h);
        send_rx(8'hFA);
        s0 = strobe_cnt;
        pulse_start();
        repeat (50) @(negedge clk_sys);
        n_checks++;
        if (strobe_cnt != s0) begin n_fail++; $display("FAIL ign_no_strobe: got %0d strobes, expected 0", strobe_cnt - s0); end
        n_checks++;
        if ({busy, retry_cnt} !== 3'b100) begin
            n_fail++; $display("FAIL ign_state: got busy=%b retry=%0d, expected busy=1 retry=0", busy, retry_cnt);
        end
        send_rx(8'hAA);
        send_rx(8'h00);
        wait_strobe(50, ok, d);
        n_checks++;
        if (!(ok && d === 8'hF4)) begin n_fail++; $display("FAIL ign_en_strobe: got ok=%0b data=%h, expected ok=1 data=f4", ok, d); end
        send_done(100, h);
        send_rx(8'hFA);
        @(negedge clk_sys);
        n_checks++;
        if ({init_done, retry_cnt} !== 3'b100) begin
            n_fail++; $display("FAIL ign_done: got done=%b retry=%0d, expected done=1 retry=0", init_done, retry_cnt);
        end
    endtask

    initial begin
        rst_n      = 1'b1;
        start      = 1'b0;
        tx_wr_done = 1'b0;
        rx_valid   = 1'b0;
        rx_data    = 8'h00;
        #2 rst_n = 1'b0;
        test_reset();
        repeat (2) @(negedge clk_sys);
        rst_n = 1'b1;
        test_normal();
        test_nak_retry();
        test_timeout_error();
        test_pkt_passthrough();
        test_wait_id_bad();
        test_reset_mid();
        test_start_ignored();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
